// File: rtl/mdu_issue_controller.sv
// Issue controller for the shared multiply/divide unit: launches M-extension ops,
// freezes the front end while the unit runs and releases the result into EX/MEM.
module mdu_issue_controller #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_is_mul,
    input  logic            ex_is_div,
    input  logic            flush,
    input  logic            mem_stall,
    input  logic [XLEN-1:0] mdu_result,
    output logic            mdu_start,
    output logic            mdu_abort,
    output logic            stall_ex,
    output logic            exmem_kill,
    output logic            result_valid,
    output logic [XLEN-1:0] mul_div_result,
    output logic            busy,
    output logic [31:0]     stall_cycles
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   result_q;
    logic              armed;
    logic              launch;

    // armed stays low for the first cycle after reset so no op launches while
    // the surrounding pipeline is still coming out of reset.
    assign launch = armed & ex_valid & (ex_is_mul | ex_is_div) & ~flush & (state == IDLE);

    // Control outputs must react to the EX instruction in the same cycle, so they
    // are decoded from the registered state rather than registered themselves.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mdu_start    = 1'b0;
        mdu_abort    = 1'b0;
        stall_ex     = 1'b0;
        exmem_kill   = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                mdu_start  = launch;
                stall_ex   = launch;
                exmem_kill = launch;
            end
            BUSY: begin
                mdu_abort  = flush;
                stall_ex   = ~flush;
                exmem_kill = 1'b1;
            end
            DONE: begin
                mdu_abort    = flush;
                stall_ex     = ~flush & mem_stall;
                exmem_kill   = flush;
                result_valid = ~flush;
            end
            default: ;
        endcase
    end

    assign busy           = (state != IDLE);
    assign mul_div_result = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            result_q     <= '0;
            stall_cycles <= '0;
            armed        <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (stall_ex && state != DONE && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state <= BUSY;
                        // Divide wins when both decode bits are set.
                        cnt   <= ex_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        result_q <= mdu_result;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (flush || !mem_stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
